// File: rtl/encoder_disparity_ctrl.sv
// Running-disparity control stage ahead of the 5b/6b and 3b/4b encoders.
// Registers each character with its complement, alternate-x.7 and K-error controls.
module encoder_disparity_ctrl #(
    parameter logic RD_INIT = 1'b0
) (
    input  logic       SBYTECLK,
    input  logic       RESET,
    input  logic [7:0] DIN,
    input  logic       KIN,
    input  logic       VALID_IN,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       E,
    output logic       F,
    output logic       G,
    output logic       H,
    output logic       K,
    output logic       COMPLS6,
    output logic       COMPLS4,
    output logic       ALT7,
    output logic       VALID_OUT,
    output logic       RD_OUT,
    output logic       KERR
);

    logic [7:0] data_q, data_d;
    logic       k_q, k_d;
    logic       compls6_q, compls6_d;
    logic       compls4_q, compls4_d;
    logic       alt7_q, alt7_d;
    logic       valid_q, valid_d;
    logic       rd_q, rd_d;
    logic       kerr_q, kerr_d;

    logic [4:0] x;
    logic [2:0] y;
    logic       u6, s6, k28, rd_mid;
    logic       u4, s4;
    logic       alt_x, k_legal;

    // Sub-block classification of the incoming byte
    always_comb begin
        x = DIN[4:0];
        y = DIN[7:5];

        u6 = 1'b0;
        case (x)
            5'd0, 5'd1, 5'd2, 5'd4, 5'd8, 5'd15, 5'd16,
            5'd23, 5'd24, 5'd27, 5'd29, 5'd30, 5'd31: u6 = 1'b1;
            default: u6 = 1'b0;
        endcase

        k28    = KIN && (x == 5'd28);
        s6     = (x == 5'd7) || k28;
        rd_mid = rd_q ^ (u6 | k28);

        u4 = (y == 3'd0) || (y == 3'd4) || (y == 3'd7);
        s4 = (y == 3'd3);

        // x.7 codes whose primary 4b form would create a run of five
        if (rd_q) begin
            alt_x = (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
        end else begin
            alt_x = (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
        end

        k_legal = (x == 5'd28) ||
                  ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) ||
                                   (x == 5'd29) || (x == 5'd30)));
    end

    always_comb begin
        data_d    = data_q;
        k_d       = k_q;
        valid_d   = 1'b0;
        compls6_d = 1'b0;
        compls4_d = 1'b0;
        alt7_d    = 1'b0;
        kerr_d    = 1'b0;
        rd_d      = rd_q;

        if (VALID_IN) begin
            data_d    = DIN;
            k_d       = KIN;
            valid_d   = 1'b1;
            compls6_d = rd_q & (u6 | s6);
            compls4_d = rd_mid & (u4 | s4);
            alt7_d    = (y == 3'd7) && (KIN || alt_x);
            kerr_d    = KIN && !k_legal;
            rd_d      = rd_mid ^ u4;
        end
    end

    always_ff @(posedge SBYTECLK) begin
        if (RESET) begin
            data_q    <= 8'h00;
            k_q       <= 1'b0;
            valid_q   <= 1'b0;
            compls6_q <= 1'b0;
            compls4_q <= 1'b0;
            alt7_q    <= 1'b0;
            kerr_q    <= 1'b0;
            rd_q      <= RD_INIT;
        end else begin
            data_q    <= data_d;
            k_q       <= k_d;
            valid_q   <= valid_d;
            compls6_q <= compls6_d;
            compls4_q <= compls4_d;
            alt7_q    <= alt7_d;
            kerr_q    <= kerr_d;
            rd_q      <= rd_d;
        end
    end

    assign A         = data_q[0];
    assign B         = data_q[1];
    assign C         = data_q[2];
    assign D         = data_q[3];
    assign E         = data_q[4];
    assign F         = data_q[5];
    assign G         = data_q[6];
    assign H         = data_q[7];
    assign K         = k_q;
    assign COMPLS6   = compls6_q;
    assign COMPLS4   = compls4_q;
    assign ALT7      = alt7_q;
    assign VALID_OUT = valid_q;
    assign RD_OUT    = rd_q;
    assign KERR      = kerr_q;

endmodule

// File: tb/tb_encoder_disparity_ctrl.sv
// Scoreboard bench for encoder_disparity_ctrl: directed characters with hand-derived controls.
module tb_encoder_disparity_ctrl;

    logic       SBYTECLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] DIN = 8'h00;
    logic       KIN = 1'b0;
    logic       VALID_IN = 1'b0;
    logic       A, B, C, D, E, F, G, H, K;
    logic       COMPLS6, COMPLS4, ALT7, VALID_OUT, RD_OUT, KERR;

    encoder_disparity_ctrl #(.RD_INIT(1'b0)) dut (
        .SBYTECLK (SBYTECLK),
        .RESET    (RESET),
        .DIN      (DIN),
        .KIN      (KIN),
        .VALID_IN (VALID_IN),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .E        (E),
        .F        (F),
        .G        (G),
        .H        (H),
        .K        (K),
        .COMPLS6  (COMPLS6),
        .COMPLS4  (COMPLS4),
        .ALT7     (ALT7),
        .VALID_OUT(VALID_OUT),
        .RD_OUT   (RD_OUT),
        .KERR     (KERR)
    );

    always #5 SBYTECLK = ~SBYTECLK;

    typedef struct {
        int         id;
        logic       valid;
        logic       c6;
        logic       c4;
        logic       alt7;
        logic       kerr;
        logic       rd;
        logic [8:0] data;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         vec_id = 0;
    logic [7:0] hold_data = 8'h00;
    logic       hold_k = 1'b0;
    logic       started = 1'b0;

    task automatic chk(input string name, input int id, input logic [8:0] act, input logic [8:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, id, act, req);
        end
    endtask

    task automatic send(input logic rst, input logic v, input logic k, input logic [7:0] din,
                        input logic e6, input logic e4, input logic ea, input logic ek,
                        input logic erd);
        exp_t e;
        @(negedge SBYTECLK);
        RESET    = rst;
        VALID_IN = v;
        KIN      = k;
        DIN      = din;
        if (rst) begin
            hold_data = 8'h00;
            hold_k    = 1'b0;
        end else if (v) begin
            hold_data = din;
            hold_k    = k;
        end
        e.id    = vec_id;
        e.valid = v & ~rst;
        e.c6    = e6;
        e.c4    = e4;
        e.alt7  = ea;
        e.kerr  = ek;
        e.rd    = erd;
        e.data  = {hold_k, hold_data};
        sb.push_back(e);
        vec_id++;
    endtask

    // Monitor: every entry pushed at a negedge is due right after the following rising edge
    always begin
        exp_t e;
        @(posedge SBYTECLK);
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            started = 1'b1;
            chk("valid_out", e.id, {8'h00, VALID_OUT}, {8'h00, e.valid});
            chk("compls6",   e.id, {8'h00, COMPLS6},   {8'h00, e.c6});
            chk("compls4",   e.id, {8'h00, COMPLS4},   {8'h00, e.c4});
            chk("alt7",      e.id, {8'h00, ALT7},      {8'h00, e.alt7});
            chk("kerr",      e.id, {8'h00, KERR},      {8'h00, e.kerr});
            chk("rd_out",    e.id, {8'h00, RD_OUT},    {8'h00, e.rd});
            chk("data_k",    e.id, {K, H, G, F, E, D, C, B, A}, e.data);
        end else if (started && VALID_OUT) begin
            chk("spurious_valid", -1, {8'h00, VALID_OUT}, 9'h000);
        end
    end

    initial begin
        //   rst v  k  din    c6 c4 a7 ke rd
        send(1, 0, 0, 8'h00, 0, 0, 0, 0, 0);  // reset
        send(0, 1, 0, 8'h00, 0, 1, 0, 0, 0);  // D.0.0 at RD-
        send(0, 1, 1, 8'hBC, 0, 0, 0, 0, 1);  // K.28.5 at RD-
        send(0, 1, 1, 8'hBC, 1, 0, 0, 0, 0);  // K.28.5 at RD+
        send(0, 1, 0, 8'hF1, 0, 0, 1, 0, 1);  // D.17.7 at RD-: alternate code
        send(0, 1, 0, 8'h03, 0, 1, 0, 0, 0);  // D.3.0 at RD+
        send(0, 1, 0, 8'hEB, 0, 0, 0, 0, 1);  // D.11.7 at RD-: primary code
        send(0, 1, 0, 8'hEB, 0, 1, 1, 0, 0);  // D.11.7 at RD+: alternate code
        send(0, 1, 1, 8'h3C, 0, 0, 0, 0, 1);  // K.28.1 legal
        send(0, 1, 1, 8'h21, 1, 0, 0, 1, 0);  // K.1.1 illegal, RD still moves
        send(0, 1, 1, 8'hF7, 0, 1, 1, 0, 0);  // K.23.7 legal
        send(0, 1, 0, 8'h20, 0, 0, 0, 0, 1);  // D.0.1 at RD-
        send(0, 1, 0, 8'h67, 1, 1, 0, 0, 1);  // D.7.3 at RD+: both complemented
        send(0, 0, 1, 8'hFF, 0, 0, 0, 0, 1);  // idle x3, data and RD held
        send(0, 0, 1, 8'hFF, 0, 0, 0, 0, 1);
        send(0, 0, 1, 8'hFF, 0, 0, 0, 0, 1);
        send(0, 1, 0, 8'h03, 0, 1, 0, 0, 0);  // D.3.0 uses held RD+
        send(0, 1, 0, 8'h20, 0, 0, 0, 0, 1);  // D.0.1 at RD-
        send(0, 1, 0, 8'hF2, 0, 1, 0, 0, 0);  // D.18.7 at RD+: no alternate
        send(0, 1, 0, 8'h20, 0, 0, 0, 0, 1);  // D.0.1 at RD-
        send(1, 1, 1, 8'hFF, 0, 0, 0, 0, 0);  // reset while RD+ with valid high
        send(0, 1, 0, 8'hF1, 0, 0, 1, 0, 1);  // D.17.7 after reset starts at RD-
        send(0, 0, 0, 8'h00, 0, 0, 0, 0, 1);  // trailing idle

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge SBYTECLK);
        #3;
        chk("scoreboard_drained", -1, {8'h00, (sb.size() == 0)}, 9'h001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
